dmem_responder: RTL

- Data-memory responder at the far end of the datapath's load/store interface. Receives the address (ALU result), store data and a write strobe from the processor side.
- Services each request from a word-organised RAM after a configurable number of wait cycles, then returns read data with a one-cycle acknowledge.
- Lets the team move from an ideal combinational data memory to a latency-bearing memory with a defined handshake and error reporting.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/ram_sp.sv | 30 +++
 rtl/dmem_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // True when addr is word-aligned and falls inside [base, base + depth*4).
    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned depth);
        logic [32:0] off;
        logic [32:0] lim;
        lim = 33'(depth) << 2;
        off = {1'b0, addr} - {1'b0, base};
        return (addr[1:0] == 2'b00) && (addr >= base) && (off < lim);
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, word organised, registered read, contents not reset.
module ram_sp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: latches a request, waits LATENCY edges, then commits or reads
// the RAM and pulses ack for one cycle with an error flag for bad addresses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(LATENCY + 1);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              ack_q, err_q, busy_q, rd_valid_q;

    logic              commit, c_we, c_ok;
    logic [31:0]       c_addr, c_off;
    logic [WORD_W-1:0] c_wdata, ram_rdata;
    logic [IdxW-1:0]   c_idx;

    // With LATENCY = 1 the commit edge is the acceptance edge, so use the live inputs.
    always_comb begin
        if (LATENCY == 1) begin
            commit = (state_q == StIdle) && req;
        end else begin
            commit = (state_q == StWait) && (cnt_q == '0);
        end
        commit  = commit && !reset;
        c_we    = (state_q == StIdle) ? we    : we_q;
        c_addr  = (state_q == StIdle) ? addr  : addr_q;
        c_wdata = (state_q == StIdle) ? wdata : wdata_q;
        c_ok    = addr_ok(c_addr, BASE_ADDR, DEPTH);
        c_off   = c_addr - BASE_ADDR;
        c_idx   = IdxW'(c_off >> 2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (LATENCY == 1) begin
                            state_q    <= StResp;
                            ack_q      <= 1'b1;
                            err_q      <= !c_ok;
                            rd_valid_q <= c_ok && !c_we;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntW'(LATENCY - 2);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q    <= StResp;
                        ack_q      <= 1'b1;
                        err_q      <= !c_ok;
                        rd_valid_q <= c_ok && !c_we;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    ack_q      <= 1'b0;
                    err_q      <= 1'b0;
                    busy_q     <= 1'b0;
                    rd_valid_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    ram_sp #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (commit && c_we && c_ok),
        .re_i   (commit && !c_we && c_ok),
        .addr_i (c_idx),
        .wdata_i(c_wdata),
        .rdata_o(ram_rdata)
    );

    // Stores and errors return zero; the RAM read register is only exposed for good loads.
    assign rdata = rd_valid_q ? ram_rdata : '0;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule
